// File: rtl/cast_table_pkg.sv
// Shared types, table indices and the cast helper for the constant-cast sequencer.
// Pure declarations: no logic, no latency, no flow control.
package cast_table_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SINGLE,
    SWEEP
  } state_t;

  localparam logic [2:0] IDX_A  = 3'd0;
  localparam logic [2:0] IDX_B  = 3'd1;
  localparam logic [2:0] IDX_45 = 3'd2;
  localparam logic [2:0] IDX_33 = 3'd3;
  localparam logic [2:0] IDX_C  = 3'd4;

  localparam int LIT_45 = 45;
  localparam int LIT_33 = 33;

  // Keep the low (width+1) bits; everything above is forced to zero, never sign-filled.
  function automatic logic [127:0] cast_zext(input logic [127:0] value, input int width);
    logic [127:0] mask;
    if (width >= 127) mask = '1;
    else              mask = (128'd1 << (width + 1)) - 128'd1;
    return value & mask;
  endfunction

endpackage

// File: rtl/cast_table_sequencer_if.sv
// Request and result channels of the cast table sequencer (valid/ready on both sides).
// master = requester/consumer side, slave = the sequencer.
interface cast_table_sequencer_if;
  logic         req_valid;
  logic         req_ready;
  logic         req_sweep;
  logic [2:0]   req_sel;
  logic         abort;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic [2:0]   out_idx;
  logic         out_last;

  modport master (
    output req_valid, req_sweep, req_sel, abort, out_ready,
    input  req_ready, out_valid, out_data, out_idx, out_last
  );

  modport slave (
    input  req_valid, req_sweep, req_sel, abort, out_ready,
    output req_ready, out_valid, out_data, out_idx, out_last
  );
endinterface

// File: rtl/cast_table_lookup.sv
// Combinational map from table index to the cast, zero-extended 128-bit value.
// Zero latency; no flow control.
module cast_table_lookup
  import cast_table_pkg::*;
#(
  parameter int A     = 10,
  parameter int B     = 12,
  parameter int C     = 16,
  parameter int WIDTH = 3
) (
  input  logic [2:0]   idx,
  output logic [127:0] dat
);

  always_comb begin
    dat = '0;
    case (idx)
      IDX_A:   dat = cast_zext(128'(A), WIDTH);
      IDX_B:   dat = cast_zext(128'(B), WIDTH);
      IDX_45:  dat = cast_zext(128'(LIT_45), WIDTH);
      IDX_33:  dat = cast_zext(128'(LIT_33), WIDTH);
      default: dat = cast_zext(128'(C), WIDTH);
    endcase
  end

endmodule

// File: rtl/cast_table_sequencer.sv
// Single-lookup / five-entry sweep sequencer over the cast table; first result 1 cycle after accept.
// Results hold while out_ready is low; requests are only taken in IDLE; abort cancels next cycle.
module cast_table_sequencer
  import cast_table_pkg::*;
#(
  parameter int A     = 10,
  parameter int B     = 12,
  parameter int C     = 16,
  parameter int WIDTH = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  cast_table_sequencer_if.slave   bus,
  output logic                    busy,
  output logic [15:0]             result_cnt
);

  generate
    if (WIDTH < 0 || WIDTH > 127) begin : g_width_chk
      $error("cast_table_sequencer: WIDTH must be in 0..127");
    end
  endgenerate

  state_t       state;
  logic [2:0]   lk_idx;
  logic [127:0] lk_dat;
  logic         hs;

  assign hs = bus.out_valid && bus.out_ready;

  function automatic logic [2:0] sel_to_idx(input logic [2:0] sel);
    return sel[2] ? IDX_C : sel;
  endfunction

  // In IDLE the lookup serves the incoming request; while sweeping it pre-fetches the next entry.
  always_comb begin
    lk_idx = IDX_A;
    if (state == IDLE) begin
      lk_idx = bus.req_sweep ? IDX_A : sel_to_idx(bus.req_sel);
    end else if (bus.out_idx != IDX_C) begin
      lk_idx = bus.out_idx + 3'd1;
    end else begin
      lk_idx = IDX_C;
    end
  end

  cast_table_lookup #(
    .A     (A),
    .B     (B),
    .C     (C),
    .WIDTH (WIDTH)
  ) u_lookup (
    .idx (lk_idx),
    .dat (lk_dat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      bus.req_ready <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_idx   <= '0;
      bus.out_last  <= 1'b0;
      busy          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            state         <= bus.req_sweep ? SWEEP : SINGLE;
            bus.req_ready <= 1'b0;
            bus.out_valid <= 1'b1;
            bus.out_data  <= lk_dat;
            bus.out_idx   <= lk_idx;
            bus.out_last  <= !bus.req_sweep;
            busy          <= 1'b1;
          end
        end
        SINGLE, SWEEP: begin
          // A handshake on the abort cycle still delivers; the block just goes quiet afterwards.
          if (bus.abort || (hs && (state == SINGLE || bus.out_idx == IDX_C))) begin
            state         <= IDLE;
            bus.req_ready <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
            busy          <= 1'b0;
          end else if (hs) begin
            bus.out_data <= lk_dat;
            bus.out_idx  <= lk_idx;
            bus.out_last <= (lk_idx == IDX_C);
          end
        end
        default: begin
          state         <= IDLE;
          bus.req_ready <= 1'b1;
          bus.out_valid <= 1'b0;
          bus.out_last  <= 1'b0;
          busy          <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_cnt <= '0;
    end else if (hs && result_cnt != 16'hFFFF) begin
      result_cnt <= result_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_cast_table_sequencer.sv
// Directed bench: WIDTH=3 is the main DUT; WIDTH=5 and WIDTH=127 copies run in lockstep for cast checks.
module tb_cast_table_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid, req_sweep, abort, out_ready;
  logic [2:0] req_sel;

  logic        busy3, busy5, busy127;
  logic [15:0] cnt3, cnt5, cnt127;

  int errors = 0;
  int checks = 0;

  logic [127:0] e3 [5];
  logic [127:0] e5 [5];
  logic [0:11]  pat;
  int           k;

  always #5 clk = ~clk;

  cast_table_sequencer_if if3 ();
  cast_table_sequencer_if if5 ();
  cast_table_sequencer_if if127 ();

  assign if3.req_valid   = req_valid;
  assign if3.req_sweep   = req_sweep;
  assign if3.req_sel     = req_sel;
  assign if3.abort       = abort;
  assign if3.out_ready   = out_ready;
  assign if5.req_valid   = req_valid;
  assign if5.req_sweep   = req_sweep;
  assign if5.req_sel     = req_sel;
  assign if5.abort       = abort;
  assign if5.out_ready   = out_ready;
  assign if127.req_valid = req_valid;
  assign if127.req_sweep = req_sweep;
  assign if127.req_sel   = req_sel;
  assign if127.abort     = abort;
  assign if127.out_ready = out_ready;

  cast_table_sequencer #(.WIDTH(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(if3.slave), .busy(busy3), .result_cnt(cnt3)
  );
  cast_table_sequencer #(.WIDTH(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .bus(if5.slave), .busy(busy5), .result_cnt(cnt5)
  );
  cast_table_sequencer #(.WIDTH(127)) dut127 (
    .clk(clk), .rst_n(rst_n), .bus(if127.slave), .busy(busy127), .result_cnt(cnt127)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    e3[0] = 128'd10; e3[1] = 128'd12; e3[2] = 128'd13; e3[3] = 128'd1;  e3[4] = 128'd0;
    e5[0] = 128'd10; e5[1] = 128'd12; e5[2] = 128'd45; e5[3] = 128'd33; e5[4] = 128'd16;
    pat = 12'b1001_0110_0111;

    req_valid = 1'b0; req_sweep = 1'b0; req_sel = 3'd0; abort = 1'b0; out_ready = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_req_ready", 128'(if3.req_ready), 128'd1);
    chk("rst_out_valid", 128'(if3.out_valid), 128'd0);
    chk("rst_out_data",  if3.out_data,        128'd0);
    chk("rst_out_idx",   128'(if3.out_idx),   128'd0);
    chk("rst_out_last",  128'(if3.out_last),  128'd0);
    chk("rst_busy",      128'(busy3),         128'd0);
    chk("rst_cnt",       128'(cnt3),          128'd0);
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick();

    // Single lookup of entry 2: 45 mod 16 = 13.
    req_valid = 1'b1; req_sweep = 1'b0; req_sel = 3'd2; out_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    chk("sgl_valid", 128'(if3.out_valid), 128'd1);
    chk("sgl_data",  if3.out_data,        128'd13);
    chk("sgl_idx",   128'(if3.out_idx),   128'd2);
    chk("sgl_last",  128'(if3.out_last),  128'd1);
    chk("sgl_rdy_lo", 128'(if3.req_ready), 128'd0);
    chk("sgl_busy",  128'(busy3),         128'd1);
    tick();
    chk("sgl_done_valid", 128'(if3.out_valid), 128'd0);
    chk("sgl_rdy_back",   128'(if3.req_ready), 128'd1);
    chk("sgl_cnt",        128'(cnt3),          128'd1);
    chk("sgl_idle_busy",  128'(busy3),         128'd0);

    // Full sweep at full throughput; req_sel must be ignored.
    req_valid = 1'b1; req_sweep = 1'b1; req_sel = 3'd5;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("sw_valid%0d", i), 128'(if3.out_valid), 128'd1);
      chk($sformatf("sw_data%0d", i),  if3.out_data,        e3[i]);
      chk($sformatf("sw_idx%0d", i),   128'(if3.out_idx),   128'(i));
      chk($sformatf("sw_last%0d", i),  128'(if3.out_last),  128'(i == 4));
      chk($sformatf("sw5_data%0d", i),   if5.out_data,   e5[i]);
      chk($sformatf("sw127_data%0d", i), if127.out_data, e5[i]);
      chk($sformatf("sw127_valid%0d", i), 128'(if127.out_valid), 128'd1);
      tick();
    end
    chk("sw_end_valid", 128'(if3.out_valid), 128'd0);
    chk("sw_end_rdy",   128'(if3.req_ready), 128'd1);
    chk("sw_cnt",       128'(cnt3),          128'd6);

    // Sweep under a stalling consumer: every result must hold until taken.
    req_valid = 1'b1; req_sweep = 1'b1;
    tick();
    req_valid = 1'b0;
    k = 0;
    for (int c = 0; c < 30 && k < 5; c++) begin
      out_ready = pat[c % 12];
      chk($sformatf("st_valid_c%0d", c), 128'(if3.out_valid), 128'd1);
      chk($sformatf("st_data_c%0d", c),  if3.out_data,        e3[k]);
      chk($sformatf("st_idx_c%0d", c),   128'(if3.out_idx),   128'(k));
      chk($sformatf("st_last_c%0d", c),  128'(if3.out_last),  128'(k == 4));
      if (out_ready) k++;
      tick();
    end
    chk("st_all_taken", 128'(k), 128'd5);
    chk("st_end_valid", 128'(if3.out_valid), 128'd0);
    chk("st_cnt",       128'(cnt3),          128'd11);

    // Abort coinciding with the handshake of entry 2: three results delivered.
    out_ready = 1'b1; req_valid = 1'b1; req_sweep = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    chk("ab_idx",  128'(if3.out_idx), 128'd2);
    chk("ab_data", if3.out_data,      128'd13);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_valid", 128'(if3.out_valid), 128'd0);
    chk("ab_last",  128'(if3.out_last),  128'd0);
    chk("ab_busy",  128'(busy3),         128'd0);
    chk("ab_rdy",   128'(if3.req_ready), 128'd1);
    chk("ab_cnt",   128'(cnt3),          128'd14);
    tick();
    chk("ab_quiet", 128'(if3.out_valid), 128'd0);

    // Abort in IDLE alongside a request must not block the accept.
    abort = 1'b1; req_valid = 1'b1; req_sweep = 1'b0; req_sel = 3'd1;
    tick();
    abort = 1'b0; req_valid = 1'b0;
    chk("ia_valid", 128'(if3.out_valid), 128'd1);
    chk("ia_data",  if3.out_data,        128'd12);
    chk("ia_idx",   128'(if3.out_idx),   128'd1);
    chk("ia_last",  128'(if3.out_last),  128'd1);
    tick();
    chk("ia_cnt", 128'(cnt3), 128'd15);

    // Asynchronous reset between edges in the middle of a stalled sweep.
    req_valid = 1'b1; req_sweep = 1'b1;
    tick();
    req_valid = 1'b0; out_ready = 1'b0;
    tick();
    chk("ar_hold_idx",  128'(if3.out_idx), 128'd0);
    chk("ar_hold_data", if3.out_data,      128'd10);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", 128'(if3.out_valid), 128'd0);
    chk("ar_data",  if3.out_data,        128'd0);
    chk("ar_idx",   128'(if3.out_idx),   128'd0);
    chk("ar_last",  128'(if3.out_last),  128'd0);
    chk("ar_busy",  128'(busy3),         128'd0);
    chk("ar_rdy",   128'(if3.req_ready), 128'd1);
    chk("ar_cnt",   128'(cnt3),          128'd0);
    @(negedge clk) rst_n = 1'b1;
    out_ready = 1'b1; req_valid = 1'b1; req_sweep = 1'b0; req_sel = 3'd6;
    tick();
    req_valid = 1'b0;
    chk("rc_data",     if3.out_data,        128'd0);
    chk("rc_idx",      128'(if3.out_idx),   128'd4);
    chk("rc_last",     128'(if3.out_last),  128'd1);
    chk("rc5_data",    if5.out_data,        128'd16);
    chk("rc5_idx",     128'(if5.out_idx),   128'd4);
    chk("rc5_valid",   128'(if5.out_valid), 128'd1);
    chk("rc127_data",  if127.out_data,      128'd16);
    chk("rc127_last",  128'(if127.out_last), 128'd1);
    chk("rc127_idx",   128'(if127.out_idx), 128'd4);
    chk("rc5_last",    128'(if5.out_last),  128'd1);
    tick();
    chk("rc_valid_lo", 128'(if3.out_valid), 128'd0);
    chk("rc_cnt",      128'(cnt3),          128'd1);
    chk("rc5_cnt",     128'(cnt5),          128'd1);
    chk("rc127_cnt",   128'(cnt127),        128'd1);
    chk("rc5_busy",    128'(busy5),         128'd0);
    chk("rc127_busy",  128'(busy127),       128'd0);
    chk("rc5_rdy",     128'(if5.req_ready), 128'd1);
    chk("rc127_rdy",   128'(if127.req_ready), 128'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
